iq_stream_packer: RTL and testbench

Transmit-side counterpart of the interleaved I/Q sample stream consumed by `acquisition`. The block accepts complex baseband samples as parallel 16-bit I/Q pairs and buffers them in a small FIFO. It emits them as a single 16-bit word stream, I first then Q, byte-swapped to the little-endian on-disk/host format. It sits between the spoofer signal generator and the sample sink (DMA/file writer/DAC bridge).

---
 rtl/iq_stream_packer_if.sv | 31 +++
 rtl/iq_stream_packer.sv | 147 ++++++++++++++
 tb/tb_iq_stream_packer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iq_stream_packer_if.sv
// Bundle for the I/Q pair input side and the interleaved word output side of iq_stream_packer.
// The master modport is the environment view (source + sink); slave is the packer itself.
interface iq_stream_packer_if #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              enable;
  logic [DATA_W-1:0] i_in;
  logic [DATA_W-1:0] q_in;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] word_out;
  logic              word_is_q;
  logic              word_valid;
  logic              word_ready;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;
  logic [15:0]       drop_count;

  modport master (
    output enable, i_in, q_in, in_valid, word_ready,
    input  in_ready, word_out, word_is_q, word_valid, fifo_level, overflow, drop_count
  );

  modport slave (
    input  enable, i_in, q_in, in_valid, word_ready,
    output in_ready, word_out, word_is_q, word_valid, fifo_level, overflow, drop_count
  );
endinterface

// File: rtl/iq_stream_packer.sv
// Buffers parallel I/Q pairs in a small FIFO and serialises them as I-then-Q words,
// optionally byte-swapped to little-endian host order.
module iq_stream_packer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int SWAP_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  iq_stream_packer_if.slave      bus,
  output logic [1:0]             o_dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
  // waits on ready, and in_ready depends only on enable and registered occupancy.

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_SEND_I = 2'd1,
    S_SEND_Q = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [DATA_W-1:0] r_mem_i [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_q [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] r_q_hold;
  logic              r_overflow;
  logic [15:0]       r_drop_count;

  logic              w_full;
  logic              w_empty;
  logic              w_in_ready;
  logic              w_push;
  logic              w_reject;
  logic              w_pop;
  logic              w_load_q;
  logic [DATA_W-1:0] w_head_i;
  logic [DATA_W-1:0] w_head_i_sw;
  logic [DATA_W-1:0] w_hold_q_sw;

  assign w_full     = (r_level == LW'(FIFO_DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_in_ready = bus.enable && !w_full;
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_reject   = bus.in_valid && bus.enable && !w_in_ready;
  assign w_head_i   = r_mem_i[r_rd_ptr];

  // The swapped form assumes 16-bit components; pass-through works for any width.
  generate
    if (SWAP_BYTES != 0) begin : g_swap
      assign w_head_i_sw = {w_head_i[7:0], w_head_i[DATA_W-1:8]};
      assign w_hold_q_sw = {r_q_hold[7:0], r_q_hold[DATA_W-1:8]};
    end else begin : g_pass
      assign w_head_i_sw = w_head_i;
      assign w_hold_q_sw = r_q_hold;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_EMPTY;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_EMPTY:  if (!w_empty)       w_next_state = S_SEND_I;
      S_SEND_I: if (bus.word_ready) w_next_state = S_SEND_Q;
      S_SEND_Q: if (bus.word_ready) w_next_state = w_empty ? S_EMPTY : S_SEND_I;
      default:                      w_next_state = S_EMPTY;
    endcase
  end

  always_comb begin
    w_pop    = 1'b0;
    w_load_q = 1'b0;
    case (r_state)
      S_EMPTY:  w_pop    = !w_empty;
      S_SEND_I: w_load_q = bus.word_ready;
      S_SEND_Q: w_pop    = bus.word_ready && !w_empty;
      default:  w_pop    = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_i[r_wr_ptr] <= bus.i_in;
      r_mem_q[r_wr_ptr] <= bus.q_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Q is held raw alongside the emitted I so the pair leaves the FIFO in one pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word   <= '0;
      r_q_hold <= '0;
    end else if (w_pop) begin
      r_word   <= w_head_i_sw;
      r_q_hold <= r_mem_q[r_rd_ptr];
    end else if (w_load_q) begin
      r_word   <= w_hold_q_sw;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_reject) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.word_out   = r_word;
  assign bus.word_is_q  = (r_state == S_SEND_Q);
  assign bus.word_valid = (r_state != S_EMPTY);
  assign bus.fifo_level = r_level;
  assign bus.overflow   = r_overflow;
  assign bus.drop_count = r_drop_count;
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_iq_stream_packer.sv
// Bench for iq_stream_packer: directed scenarios plus randomised traffic against a
// queue-based model of the pair stream.
module tb_iq_stream_packer;
  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  iq_stream_packer_if #(.DATA_W(W), .FIFO_DEPTH(DEPTH)) dif ();

  iq_stream_packer #(.DATA_W(W), .FIFO_DEPTH(DEPTH), .SWAP_BYTES(1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (dif),
    .o_dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  logic [W:0] exp_q[$];
  logic [W:0] got_q[$];
  int         take_cyc[$];
  int         m_pending, m_drops, stall_bad, lvl_bad, rdy_bad, cyc;
  logic       prev_stall;
  logic [W:0] prev_word;

  function automatic logic [W-1:0] swap16(input logic [W-1:0] x);
    return (x << 8) | (x >> 8);
  endfunction

  function automatic int first_diff();
    if (got_q.size() != exp_q.size()) return -2;
    for (int i = 0; i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    exp_q.delete(); got_q.delete(); take_cyc.delete();
    m_pending = 0; m_drops = 0; stall_bad = 0; lvl_bad = 0; rdy_bad = 0; cyc = 0;
    prev_stall = 1'b0; prev_word = '0;
  endtask

  // Inputs are set at the falling edge; this samples, updates the model, and steps one clock.
  task automatic cycle();
    int   e_lvl;
    logic e_rdy;
    #1;
    e_lvl = m_pending - (dif.word_valid ? 1 : 0);
    e_rdy = dif.enable && (e_lvl < DEPTH);
    if (dif.fifo_level !== LW'(e_lvl)) lvl_bad++;
    if (dif.in_ready !== e_rdy) rdy_bad++;
    if (prev_stall && (dif.word_valid !== 1'b1 || {dif.word_is_q, dif.word_out} !== prev_word))
      stall_bad++;
    if (dif.in_valid && e_rdy) begin
      exp_q.push_back({1'b0, swap16(dif.i_in)});
      exp_q.push_back({1'b1, swap16(dif.q_in)});
      m_pending++;
    end else if (dif.in_valid && dif.enable) begin
      if (m_drops < 65535) m_drops++;
    end
    if (dif.word_valid && dif.word_ready) begin
      got_q.push_back({dif.word_is_q, dif.word_out});
      take_cyc.push_back(cyc);
      if (dif.word_is_q) m_pending--;
    end
    prev_stall = dif.word_valid && !dif.word_ready;
    prev_word  = {dif.word_is_q, dif.word_out};
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset_n = 1'b0;
    dif.enable = 1'b1; dif.in_valid = 1'b0; dif.word_ready = 1'b0;
    dif.i_in = '0; dif.q_in = '0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int g = 0;
    dif.in_valid = 1'b0;
    dif.word_ready = 1'b1;
    while (got_q.size() < exp_q.size() && g < budget) begin
      cycle();
      g++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    dif.enable = 1'b1; dif.in_valid = 1'b0; dif.word_ready = 1'b0;
    dif.i_in = '0; dif.q_in = '0;
    model_clear();
    repeat (2) @(negedge clk);
    total++; if (dif.word_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", dif.word_valid); end
    total++; if (dif.word_out !== 16'h0) begin bad++; $display("FAIL rst_word got=%h exp=0000", dif.word_out); end
    total++; if (dif.fifo_level !== '0) begin bad++; $display("FAIL rst_level got=%0d exp=0", dif.fifo_level); end
    total++; if (dif.overflow !== 1'b0 || dif.drop_count !== 16'h0) begin
      bad++; $display("FAIL rst_drop got=%b/%0d exp=0/0", dif.overflow, dif.drop_count); end
    reset_n = 1'b1;
    #1;
    total++; if (dif.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", dif.in_ready); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    dif.enable = 1'b0;
    #1;
    total++; if (dif.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready_dis got=%b exp=0", dif.in_ready); end
    dif.enable = 1'b1;
  endtask

  task automatic test_single_pair();
    reset_dut();
    dif.word_ready = 1'b1;
    dif.i_in = 16'h1234; dif.q_in = 16'hABCD; dif.in_valid = 1'b1;
    cycle();
    dif.in_valid = 1'b0;
    total++; if (dif.word_valid !== 1'b0 || dif.fifo_level !== LW'(1)) begin
      bad++; $display("FAIL single_accept valid=%b level=%0d exp 0/1", dif.word_valid, dif.fifo_level); end
    cycle();
    total++; if ({dif.word_valid, dif.word_is_q, dif.word_out} !== {2'b10, 16'h3412}) begin
      bad++; $display("FAIL single_i got=%b/%b/%h exp=1/0/3412", dif.word_valid, dif.word_is_q, dif.word_out); end
    cycle();
    total++; if ({dif.word_valid, dif.word_is_q, dif.word_out} !== {2'b11, 16'hCDAB}) begin
      bad++; $display("FAIL single_q got=%b/%b/%h exp=1/1/cdab", dif.word_valid, dif.word_is_q, dif.word_out); end
    cycle();
    total++; if (dif.word_valid !== 1'b0) begin bad++; $display("FAIL single_end valid=%b exp=0", dif.word_valid); end
    total++; if (first_diff() != -1) begin bad++; $display("FAIL single_seq diff_at=%0d exp=-1", first_diff()); end
  endtask

  task automatic test_stream20();
    int n = 0;
    int g = 0;
    reset_dut();
    dif.word_ready = 1'b1;
    while (n < 20 && g < 200) begin
      if (dif.in_ready) begin
        dif.i_in = 16'(n); dif.q_in = 16'h8000 + 16'(n); dif.in_valid = 1'b1; n++;
      end else begin
        dif.in_valid = 1'b0;
      end
      cycle();
      g++;
    end
    drain(100);
    total++; if (n != 20) begin bad++; $display("FAIL s20_pushed got=%0d exp=20", n); end
    total++; if (got_q.size() != 40) begin bad++; $display("FAIL s20_count got=%0d exp=40", got_q.size()); end
    total++; if (first_diff() != -1) begin bad++; $display("FAIL s20_seq diff_at=%0d exp=-1", first_diff()); end
    total++; if (got_q.size() == 40 && (take_cyc[39] - take_cyc[0]) != 39) begin
      bad++; $display("FAIL s20_gapless span=%0d exp=39", take_cyc[39] - take_cyc[0]); end
    total++; if (dif.drop_count !== 16'h0 || dif.overflow !== 1'b0) begin
      bad++; $display("FAIL s20_drops got=%0d/%b exp=0/0", dif.drop_count, dif.overflow); end
    total++; if (lvl_bad != 0 || rdy_bad != 0) begin
      bad++; $display("FAIL s20_level lvl_err=%0d rdy_err=%0d exp=0/0", lvl_bad, rdy_bad); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    reset_dut();
    dif.word_ready = 1'b0;
    while (dif.in_ready && n < 20) begin
      dif.i_in = 16'h1000 + 16'(n); dif.q_in = 16'h2000 + 16'(n); dif.in_valid = 1'b1;
      cycle();
      n++;
    end
    total++; if (n != 9) begin bad++; $display("FAIL bp_accepted got=%0d exp=9", n); end
    total++; if (dif.fifo_level !== LW'(8)) begin bad++; $display("FAIL bp_level got=%0d exp=8", dif.fifo_level); end
    repeat (3) begin
      dif.i_in = 16'hDEAD; dif.q_in = 16'hBEEF; dif.in_valid = 1'b1;
      cycle();
    end
    dif.in_valid = 1'b0;
    total++; if (dif.overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow got=%b exp=1", dif.overflow); end
    total++; if (dif.drop_count !== 16'd3) begin bad++; $display("FAIL bp_drops got=%0d exp=3", dif.drop_count); end
    drain(100);
    total++; if (got_q.size() != 18) begin bad++; $display("FAIL bp_count got=%0d exp=18", got_q.size()); end
    total++; if (first_diff() != -1) begin bad++; $display("FAIL bp_seq diff_at=%0d exp=-1", first_diff()); end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      dif.in_valid   = 1'($urandom_range(0, 1));
      dif.i_in       = 16'($urandom);
      dif.q_in       = 16'($urandom);
      dif.word_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    drain(200);
    total++; if (first_diff() != -1) begin bad++; $display("FAIL rnd_seq diff_at=%0d exp=-1", first_diff()); end
    total++; if (dif.drop_count !== 16'(m_drops)) begin
      bad++; $display("FAIL rnd_drops got=%0d exp=%0d", dif.drop_count, m_drops); end
    total++; if (dif.overflow !== (m_drops > 0)) begin
      bad++; $display("FAIL rnd_overflow got=%b exp=%b", dif.overflow, m_drops > 0); end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL rnd_stall_stable violations=%0d exp=0", stall_bad); end
    total++; if (lvl_bad != 0 || rdy_bad != 0) begin
      bad++; $display("FAIL rnd_level lvl_err=%0d rdy_err=%0d exp=0/0", lvl_bad, rdy_bad); end
  endtask

  task automatic test_reset_mid_pair();
    int g = 0;
    reset_dut();
    dif.word_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dif.i_in = 16'h4000 + 16'(i); dif.q_in = 16'h6000 + 16'(i); dif.in_valid = 1'b1;
      cycle();
    end
    dif.in_valid = 1'b0;
    cycle();
    dif.word_ready = 1'b1;
    cycle();
    dif.word_ready = 1'b0;
    total++; if (dif.word_is_q !== 1'b1 || dif.fifo_level !== LW'(4)) begin
      bad++; $display("FAIL mid_setup is_q=%b level=%0d exp=1/4", dif.word_is_q, dif.fifo_level); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if ({dif.word_valid, dif.word_is_q, dif.word_out} !== '0 || dif.fifo_level !== '0) begin
      bad++; $display("FAIL mid_async got=%b/%b/%h/%0d exp=0/0/0000/0",
                      dif.word_valid, dif.word_is_q, dif.word_out, dif.fifo_level); end
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dif.word_ready = 1'b1;
    dif.i_in = 16'h5566; dif.q_in = 16'h7788; dif.in_valid = 1'b1;
    cycle();
    dif.in_valid = 1'b0;
    while (got_q.size() < 2 && g < 20) begin
      cycle();
      g++;
    end
    total++; if (got_q.size() != 2 || got_q[0] !== {1'b0, 16'h6655} || got_q[1] !== {1'b1, 16'h8877}) begin
      bad++; $display("FAIL mid_after count=%0d first=%h exp=2/06655", got_q.size(),
                      (got_q.size() > 0) ? got_q[0] : 17'h0); end
  endtask

  task automatic test_enable_off();
    int seen_ready = 0;
    reset_dut();
    dif.word_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dif.i_in = 16'(i * 3 + 1); dif.q_in = 16'(i * 5 + 2); dif.in_valid = 1'b1;
      cycle();
    end
    dif.enable = 1'b0;
    dif.word_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dif.in_valid = 1'b1;
      dif.i_in = 16'($urandom); dif.q_in = 16'($urandom);
      #1;
      if (dif.in_ready) seen_ready++;
      cycle();
    end
    dif.in_valid = 1'b0;
    total++; if (seen_ready != 0) begin bad++; $display("FAIL en_in_ready high_cycles=%0d exp=0", seen_ready); end
    total++; if (dif.overflow !== 1'b0 || dif.drop_count !== 16'h0) begin
      bad++; $display("FAIL en_drops got=%b/%0d exp=0/0", dif.overflow, dif.drop_count); end
    total++; if (got_q.size() != 6 || first_diff() != -1) begin
      bad++; $display("FAIL en_drain count=%0d diff_at=%0d exp=6/-1", got_q.size(), first_diff()); end
    dif.enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_stream20();
    test_backpressure();
    test_random();
    test_reset_mid_pair();
    test_enable_off();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
